// File: rtl/enemy_spawn_ctrl.sv
// -----------------------------------------------------------------------------
// enemy_spawn_ctrl
//
// Purpose:
//   Initiator side of the enemy spawn interface. Runs on the slow spawn clock,
//   decides when and in which lane each of the two enemy car slots launches,
//   handshakes with the enemy engines through their busy acknowledges, owns
//   the difficulty ramp (spawn / enemy clock accelerators and level) and
//   freezes the game on a collision.
//
// Ports:
//   spawn_clk    in   1   spawn tick clock
//   reset        in   1   synchronous, active-high reset
//   collision    in   1   player/enemy overlap, level-sensitive
//   slot_busy    in   2   bit i high while enemy i is on screen (acknowledge)
//   spawn_req    out  2   bit i requests launch of enemy i (one-hot or zero)
//   enemy_x0     out  10  lane X of slot 0 (197/279/361)
//   enemy_x1     out  10  lane X of slot 1
//   active_pos0  out  10  start Y of slot 0
//   active_pos1  out  10  start Y of slot 1
//   acc_spawn    out  25  accelerator for the spawn clock divider
//   acc_enemy    out  25  accelerator for the enemy clock divider
//   level        out  4   difficulty step count, saturates at 15
//   game_over    out  1   high once a collision has frozen the game
// -----------------------------------------------------------------------------
module enemy_spawn_ctrl #(
    parameter int unsigned SPAWN_GAP    = 14,
    parameter int unsigned LEVEL_PERIOD = 50,
    parameter int unsigned SPAWN_STEP   = 1000,
    parameter logic [24:0] SPAWN_LIMIT  = 25'h2625a0,
    parameter int unsigned ENEMY_STEP   = 1000,
    parameter logic [24:0] ENEMY_LIMIT  = 25'h186a0,
    parameter int unsigned ACK_TIMEOUT  = 8,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5,
    parameter logic [9:0]  START_POS    = 10'h000,
    parameter logic [9:0]  PARK_POS     = 10'h26c
) (
    input  logic        spawn_clk,
    input  logic        reset,
    input  logic        collision,
    input  logic [1:0]  slot_busy,
    output logic [1:0]  spawn_req,
    output logic [9:0]  enemy_x0,
    output logic [9:0]  enemy_x1,
    output logic [9:0]  active_pos0,
    output logic [9:0]  active_pos1,
    output logic [24:0] acc_spawn,
    output logic [24:0] acc_enemy,
    output logic [3:0]  level,
    output logic        game_over
);

    // Counter widths sized so that the largest loaded value always fits.
    localparam int GAP_W = (SPAWN_GAP    > 1) ? $clog2(SPAWN_GAP)    : 1;
    localparam int TO_W  = (ACK_TIMEOUT  > 1) ? $clog2(ACK_TIMEOUT)  : 1;
    localparam int LVL_W = (LEVEL_PERIOD > 1) ? $clog2(LEVEL_PERIOD) : 1;

    localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(SPAWN_GAP - 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [LVL_W-1:0] LVL_LAST   = LVL_W'(LEVEL_PERIOD - 1);
    localparam logic [25:0]      SP_STEP_26 = 26'(SPAWN_STEP);
    localparam logic [25:0]      EN_STEP_26 = 26'(ENEMY_STEP);
    localparam logic [25:0]      SP_LIM_26  = {1'b0, SPAWN_LIMIT};
    localparam logic [25:0]      EN_LIM_26  = {1'b0, ENEMY_LIMIT};
    localparam logic [9:0]       X_LANE0    = 10'd197;
    localparam logic [9:0]       X_LANE1    = 10'd279;
    localparam logic [9:0]       X_LANE2    = 10'd361;

    typedef enum logic [1:0] {
        ST_ARM      = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_GAP      = 2'd2,
        ST_OVER     = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t             r_state;
    logic [1:0]         r_req;
    logic [9:0]         r_x   [2];
    logic [9:0]         r_pos [2];
    logic               r_slot;          // slot owning the outstanding request
    logic [TO_W-1:0]    r_to_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [LVL_W-1:0]   r_level_cnt;
    logic [7:0]         r_lfsr;
    logic [24:0]        r_acc_spawn;
    logic [24:0]        r_acc_enemy;
    logic [3:0]         r_level;
    logic               r_game_over;

    // -------------------------------------------------------------------------
    // Next-state values and decode
    // -------------------------------------------------------------------------
    state_t             w_state_next;
    logic [1:0]         w_req_next;
    logic [9:0]         w_x_next   [2];
    logic [9:0]         w_pos_next [2];
    logic               w_slot_next;
    logic [TO_W-1:0]    w_to_next;
    logic [GAP_W-1:0]   w_gap_next;
    logic [LVL_W-1:0]   w_level_cnt_next;
    logic [7:0]         w_lfsr_next;
    logic [24:0]        w_acc_spawn_next;
    logic [24:0]        w_acc_enemy_next;
    logic [3:0]         w_level_next;
    logic               w_game_over_next;

    logic               w_collide;       // collision seen in a live state
    logic               w_run;           // live state and no collision this edge
    logic               w_free_any;
    logic               w_pick;          // lowest-index free slot
    logic               w_other;
    logic [1:0]         w_lane_raw;
    logic [1:0]         w_lane;
    logic [9:0]         w_lane_x;
    logic               w_lane_clash;
    logic               w_launch;
    logic               w_ack;
    logic               w_timeout;
    logic               w_lvl_step;
    logic [25:0]        w_sp_sum;
    logic [25:0]        w_en_sum;
    logic               w_lfsr_fb;

    function automatic logic [9:0] lane_to_x(input logic [1:0] lane);
        case (lane)
            2'd0:    lane_to_x = X_LANE0;
            2'd2:    lane_to_x = X_LANE2;
            default: lane_to_x = X_LANE1;
        endcase
    endfunction

    assign w_collide  = (r_state != ST_OVER) && collision;
    assign w_run      = (r_state != ST_OVER) && !collision;

    assign w_free_any = ~&slot_busy;
    assign w_pick     = slot_busy[0];
    assign w_other    = ~w_pick;

    // Lane code 3 folds onto the middle lane; if the other car already
    // occupies the chosen lane, rotate to the next lane so they never stack.
    assign w_lane_raw   = (r_lfsr[1:0] == 2'd3) ? 2'd1 : r_lfsr[1:0];
    assign w_lane_clash = slot_busy[w_other] && (r_x[w_other] == lane_to_x(w_lane_raw));
    assign w_lane       = !w_lane_clash        ? w_lane_raw :
                          (w_lane_raw == 2'd2) ? 2'd0       : (w_lane_raw + 2'd1);
    assign w_lane_x     = lane_to_x(w_lane);

    assign w_launch  = w_run && (r_state == ST_ARM) && w_free_any;
    assign w_ack     = w_run && (r_state == ST_WAIT_ACK) && slot_busy[r_slot];
    assign w_timeout = w_run && (r_state == ST_WAIT_ACK) && !slot_busy[r_slot]
                       && (r_to_cnt == TO_LAST);

    // Accelerator sums are one bit wider than the registers so the wrap test
    // cannot be fooled by a carry out of bit 24.
    assign w_lvl_step = w_run && (r_level_cnt == LVL_LAST);
    assign w_sp_sum   = {1'b0, r_acc_spawn} + SP_STEP_26;
    assign w_en_sum   = {1'b0, r_acc_enemy} + EN_STEP_26;

    // Fibonacci LFSR, taps 8,6,5,4 (maximal length, never reaches zero).
    assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge spawn_clk) begin
        if (reset) begin
            r_state <= ST_ARM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ARM: begin
                if (w_free_any) begin
                    w_state_next = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (slot_busy[r_slot] || (r_to_cnt == TO_LAST)) begin
                    w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_next = ST_ARM;
                end
            end
            default: begin
                w_state_next = ST_OVER;
            end
        endcase
        if (w_collide) begin
            w_state_next = ST_OVER;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: output / datapath next values
    // -------------------------------------------------------------------------
    always_comb begin
        w_slot_next      = r_slot;
        w_to_next        = r_to_cnt;
        w_gap_next       = r_gap_cnt;
        w_level_cnt_next = r_level_cnt;
        w_lfsr_next      = r_lfsr;
        w_acc_spawn_next = r_acc_spawn;
        w_acc_enemy_next = r_acc_enemy;
        w_level_next     = r_level;
        w_game_over_next = r_game_over || w_collide;

        if (w_run) begin
            w_lfsr_next = {r_lfsr[6:0], w_lfsr_fb};

            if (w_lvl_step) begin
                w_level_cnt_next = '0;
                w_acc_spawn_next = (w_sp_sum >= SP_LIM_26) ? 25'd0 : w_sp_sum[24:0];
                w_acc_enemy_next = (w_en_sum >= EN_LIM_26) ? 25'd0 : w_en_sum[24:0];
                w_level_next     = (r_level == 4'd15) ? 4'd15 : (r_level + 4'd1);
            end else begin
                w_level_cnt_next = r_level_cnt + 1'b1;
            end

            if (w_launch) begin
                w_slot_next = w_pick;
                w_to_next   = '0;
            end else if (w_ack || w_timeout) begin
                w_gap_next  = GAP_LOAD;
            end else if (r_state == ST_WAIT_ACK) begin
                w_to_next   = r_to_cnt + 1'b1;
            end else if ((r_state == ST_GAP) && (r_gap_cnt != '0)) begin
                w_gap_next  = r_gap_cnt - 1'b1;
            end
        end
    end

    // Per-slot request, lane and Y position updates.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            logic w_launch_here;
            logic w_done_here;

            assign w_launch_here = w_launch && (w_pick == 1'(gi));
            assign w_done_here   = (w_ack || w_timeout) && (r_slot == 1'(gi));

            assign w_x_next[gi]   = w_launch_here ? w_lane_x : r_x[gi];

            // An abandoned launch parks the car off-screen again.
            assign w_pos_next[gi] = w_launch_here                   ? START_POS :
                                    (w_timeout && (r_slot == 1'(gi))) ? PARK_POS  :
                                                                        r_pos[gi];

            assign w_req_next[gi] = w_collide     ? 1'b0 :
                                    w_launch_here ? 1'b1 :
                                    w_done_here   ? 1'b0 : r_req[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge spawn_clk) begin
        if (reset) begin
            r_req       <= 2'b00;
            r_x[0]      <= X_LANE1;
            r_x[1]      <= X_LANE1;
            r_pos[0]    <= PARK_POS;
            r_pos[1]    <= PARK_POS;
            r_slot      <= 1'b0;
            r_to_cnt    <= '0;
            r_gap_cnt   <= '0;
            r_level_cnt <= '0;
            r_lfsr      <= LFSR_SEED;
            r_acc_spawn <= '0;
            r_acc_enemy <= '0;
            r_level     <= '0;
            r_game_over <= 1'b0;
        end else begin
            r_req       <= w_req_next;
            r_x[0]      <= w_x_next[0];
            r_x[1]      <= w_x_next[1];
            r_pos[0]    <= w_pos_next[0];
            r_pos[1]    <= w_pos_next[1];
            r_slot      <= w_slot_next;
            r_to_cnt    <= w_to_next;
            r_gap_cnt   <= w_gap_next;
            r_level_cnt <= w_level_cnt_next;
            r_lfsr      <= w_lfsr_next;
            r_acc_spawn <= w_acc_spawn_next;
            r_acc_enemy <= w_acc_enemy_next;
            r_level     <= w_level_next;
            r_game_over <= w_game_over_next;
        end
    end

    assign spawn_req   = r_req;
    assign enemy_x0    = r_x[0];
    assign enemy_x1    = r_x[1];
    assign active_pos0 = r_pos[0];
    assign active_pos1 = r_pos[1];
    assign acc_spawn   = r_acc_spawn;
    assign acc_enemy   = r_acc_enemy;
    assign level       = r_level;
    assign game_over   = r_game_over;

endmodule

// File: tb/tb_enemy_spawn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_enemy_spawn_ctrl
//
// Self-checking bench for enemy_spawn_ctrl: a directed table, a few
// hand-written multi-cycle sequences and a randomized run, all checked every
// tick against a timestamp-based reference model of the spawn rules.
// -----------------------------------------------------------------------------
module tb_enemy_spawn_ctrl;

    localparam int          SPAWN_GAP    = 14;
    localparam int          LEVEL_PERIOD = 50;
    localparam int          SPAWN_STEP   = 1000;
    localparam int          SPAWN_LIMIT  = 'h2625a0;
    localparam int          ENEMY_STEP   = 1000;
    localparam int          ENEMY_LIMIT  = 'h186a0;
    localparam int          ACK_TIMEOUT  = 8;
    localparam logic [7:0]  LFSR_SEED    = 8'hA5;
    localparam logic [9:0]  START_POS    = 10'h000;
    localparam logic [9:0]  PARK_POS     = 10'h26c;
    // Number of steps after which each accelerator returns to zero.
    localparam int          SP_WRAP = (SPAWN_LIMIT + SPAWN_STEP - 1) / SPAWN_STEP;
    localparam int          EN_WRAP = (ENEMY_LIMIT + ENEMY_STEP - 1) / ENEMY_STEP;

    logic        spawn_clk = 1'b0;
    logic        reset     = 1'b1;
    logic        collision = 1'b0;
    logic [1:0]  slot_busy = 2'b00;
    logic [1:0]  spawn_req;
    logic [9:0]  enemy_x0, enemy_x1, active_pos0, active_pos1;
    logic [24:0] acc_spawn, acc_enemy;
    logic [3:0]  level;
    logic        game_over;

    always #5 spawn_clk = ~spawn_clk;

    enemy_spawn_ctrl dut (
        .spawn_clk   (spawn_clk),
        .reset       (reset),
        .collision   (collision),
        .slot_busy   (slot_busy),
        .spawn_req   (spawn_req),
        .enemy_x0    (enemy_x0),
        .enemy_x1    (enemy_x1),
        .active_pos0 (active_pos0),
        .active_pos1 (active_pos1),
        .acc_spawn   (acc_spawn),
        .acc_enemy   (acc_enemy),
        .level       (level),
        .game_over   (game_over)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d required %0d", nm, $time, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: tracks edge index since reset, when the next launch is
    // allowed, which slot holds a request and when it was issued.
    // -------------------------------------------------------------------------
    int          lane_x_tab [3];
    int          m_now, m_t, m_arm_at, m_req_slot, m_req_start;
    bit          m_over;
    logic [7:0]  m_lfsr;
    int          m_x   [2];
    logic [9:0]  m_pos [2];

    task automatic model_edge(input logic rst, input logic [1:0] busy, input logic coll);
        int l;
        int s;
        int j;
        if (rst) begin
            m_over = 0; m_t = 0; m_now = 0; m_arm_at = 0;
            m_req_slot = -1; m_req_start = 0; m_lfsr = LFSR_SEED;
            m_x[0] = 279; m_x[1] = 279; m_pos[0] = PARK_POS; m_pos[1] = PARK_POS;
            return;
        end
        if (m_over) return;
        if (coll) begin
            m_over = 1;
            m_req_slot = -1;
            return;
        end
        m_t++;
        if (m_req_slot >= 0) begin
            if (busy[m_req_slot]) begin
                m_req_slot = -1;
                m_arm_at   = m_now + SPAWN_GAP + 1;
            end else if (m_now - m_req_start == ACK_TIMEOUT) begin
                m_pos[m_req_slot] = PARK_POS;
                m_req_slot = -1;
                m_arm_at   = m_now + SPAWN_GAP + 1;
            end
        end else if (m_now >= m_arm_at && busy != 2'b11) begin
            s = busy[0] ? 1 : 0;
            j = 1 - s;
            l = int'(m_lfsr) % 4;
            if (l == 3) l = 1;
            if (busy[j] && m_x[j] == lane_x_tab[l]) l = (l + 1) % 3;
            m_x[s]      = lane_x_tab[l];
            m_pos[s]    = START_POS;
            m_req_slot  = s;
            m_req_start = m_now;
        end
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        m_now++;
    endtask

    task automatic model_check();
        int s;
        s = m_t / LEVEL_PERIOD;
        chk("spawn_req",   32'(spawn_req),   (m_req_slot < 0) ? 0 : (1 << m_req_slot));
        chk("enemy_x0",    32'(enemy_x0),    m_x[0]);
        chk("enemy_x1",    32'(enemy_x1),    m_x[1]);
        chk("active_pos0", 32'(active_pos0), 32'(m_pos[0]));
        chk("active_pos1", 32'(active_pos1), 32'(m_pos[1]));
        chk("acc_spawn",   32'(acc_spawn),   (s % SP_WRAP) * SPAWN_STEP);
        chk("acc_enemy",   32'(acc_enemy),   (s % EN_WRAP) * ENEMY_STEP);
        chk("level",       32'(level),       (s > 15) ? 15 : s);
        chk("game_over",   32'(game_over),   32'(m_over));
    endtask

    // One clock: drive inputs, let the edge happen, check on the falling edge.
    task automatic tick(input logic rst, input logic [1:0] busy, input logic coll);
        reset     = rst;
        slot_busy = busy;
        collision = coll;
        @(posedge spawn_clk);
        model_edge(rst, busy, coll);
        @(negedge spawn_clk);
        model_check();
    endtask

    typedef struct {
        int         n;
        logic       rst;
        logic [1:0] busy;
        logic       coll;
        logic [1:0] exp_req;
        logic [9:0] exp_pos0;
        logic [9:0] exp_pos1;
        logic       exp_go;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [9:0]  x0_saved;
        logic [1:0]  rb;
        int          cnt;
        int          over_ticks;

        lane_x_tab[0] = 197; lane_x_tab[1] = 279; lane_x_tab[2] = 361;

        // Directed table: timeout / gap, reset+collision, both busy,
        // collision during a pending request, freeze, reset recovery.
        tbl[0]  = '{2,   1'b1, 2'b00, 1'b0, 2'b00, PARK_POS,  PARK_POS,  1'b0};
        tbl[1]  = '{1,   1'b0, 2'b00, 1'b0, 2'b01, START_POS, PARK_POS,  1'b0};
        tbl[2]  = '{7,   1'b0, 2'b00, 1'b0, 2'b01, START_POS, PARK_POS,  1'b0};
        tbl[3]  = '{1,   1'b0, 2'b00, 1'b0, 2'b00, PARK_POS,  PARK_POS,  1'b0};
        tbl[4]  = '{14,  1'b0, 2'b00, 1'b0, 2'b00, PARK_POS,  PARK_POS,  1'b0};
        tbl[5]  = '{1,   1'b0, 2'b00, 1'b0, 2'b01, START_POS, PARK_POS,  1'b0};
        tbl[6]  = '{1,   1'b1, 2'b00, 1'b1, 2'b00, PARK_POS,  PARK_POS,  1'b0};
        tbl[7]  = '{1,   1'b0, 2'b11, 1'b0, 2'b00, PARK_POS,  PARK_POS,  1'b0};
        tbl[8]  = '{30,  1'b0, 2'b11, 1'b0, 2'b00, PARK_POS,  PARK_POS,  1'b0};
        tbl[9]  = '{1,   1'b0, 2'b01, 1'b0, 2'b10, PARK_POS,  START_POS, 1'b0};
        tbl[10] = '{1,   1'b0, 2'b01, 1'b1, 2'b00, PARK_POS,  START_POS, 1'b1};
        tbl[11] = '{100, 1'b0, 2'b00, 1'b0, 2'b00, PARK_POS,  START_POS, 1'b1};
        tbl[12] = '{1,   1'b1, 2'b00, 1'b0, 2'b00, PARK_POS,  PARK_POS,  1'b0};

        for (int r = 0; r < 13; r++) begin
            for (int k = 0; k < tbl[r].n; k++) begin
                tick(tbl[r].rst, tbl[r].busy, tbl[r].coll);
            end
            chk($sformatf("tbl%0d_req", r),  32'(spawn_req),   32'(tbl[r].exp_req));
            chk($sformatf("tbl%0d_pos0", r), 32'(active_pos0), 32'(tbl[r].exp_pos0));
            chk($sformatf("tbl%0d_pos1", r), 32'(active_pos1), 32'(tbl[r].exp_pos1));
            chk($sformatf("tbl%0d_go", r),   32'(game_over),   32'(tbl[r].exp_go));
        end
        $display("table: %0d rows applied, %0d compared so far", 13, n_cmp);

        // Ack two ticks after the request; next launch goes to slot 1 after
        // the gap, in a lane different from slot 0's.
        tick(1'b1, 2'b00, 1'b0);
        tick(1'b0, 2'b00, 1'b0);
        chk("ack_req_issued", 32'(spawn_req), 32'd1);
        x0_saved = enemy_x0;
        tick(1'b0, 2'b00, 1'b0);
        tick(1'b0, 2'b01, 1'b0);
        chk("ack_req_dropped", 32'(spawn_req), 32'd0);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick(1'b0, 2'b01, 1'b0);
            cnt++;
            if (spawn_req == 2'b10) break;
        end
        chk("ack_to_next_req_ticks", 32'(cnt), 32'(SPAWN_GAP + 1));
        chk("x1_differs_from_x0", 32'(enemy_x1 != x0_saved), 32'd1);
        $display("ack sequence: next request after %0d ticks, x0=%0d x1=%0d", cnt, x0_saved, enemy_x1);

        // Difficulty ramp with instant acks, through the acc_enemy wrap.
        tick(1'b1, 2'b00, 1'b0);
        for (int k = 0; k < 250; k++) begin
            rb = spawn_req;
            tick(1'b0, rb, 1'b0);
        end
        chk("ramp250_level", 32'(level), 32'd5);
        chk("ramp250_acc_spawn", 32'(acc_spawn), 32'd5000);
        chk("ramp250_acc_enemy", 32'(acc_enemy), 32'd5000);
        for (int k = 250; k < EN_WRAP * LEVEL_PERIOD - 1; k++) begin
            rb = spawn_req;
            tick(1'b0, rb, 1'b0);
        end
        chk("pre_wrap_acc_enemy", 32'(acc_enemy), 32'd99000);
        rb = spawn_req;
        tick(1'b0, rb, 1'b0);
        chk("wrap_acc_enemy", 32'(acc_enemy), 32'd0);
        chk("wrap_acc_spawn", 32'(acc_spawn), 32'd100000);
        chk("wrap_level_sat", 32'(level), 32'd15);
        tick(1'b0, 2'b00, 1'b1);
        for (int k = 0; k < 100; k++) tick(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        chk("frozen_acc_spawn", 32'(acc_spawn), 32'd100000);
        chk("frozen_game_over", 32'(game_over), 32'd1);
        $display("ramp: level=%0d acc_spawn=%0d acc_enemy=%0d", level, acc_spawn, acc_enemy);

        // Randomized traffic with occasional collisions and resets.
        tick(1'b1, 2'b00, 1'b0);
        rb = 2'b00;
        over_ticks = 0;
        for (int k = 0; k < 4000; k++) begin
            for (int b = 0; b < 2; b++) begin
                if (spawn_req[b] && ($urandom_range(0, 2) != 0)) rb[b] = 1'b1;
                else if ($urandom_range(0, 5) == 0) rb[b] = ~rb[b];
            end
            over_ticks = game_over ? over_ticks + 1 : 0;
            tick((over_ticks > 20) || ($urandom_range(0, 999) == 0), rb,
                 ($urandom_range(0, 799) == 0));
        end
        $display("random: 4000 ticks applied, %0d compared so far", n_cmp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
